sweep_ctrl: RTL and testbench
=============================

# sweep_ctrl

Sequencer that drives the enable of the 8-bit address counter in the sort/selection datapath and consumes its carry-out. The counter only responds; this block is the initiator. On a start pulse it enables the counter, counts carry events (full 256-address passes), and stops the counter on the final wrap. It then signals completion with a one-cycle done pulse. It sits between the top-level control FSM and the address counter.

## Interface
- PASSES, 1: number of carry events (wraps 255→0) to run before finishing; legal range 1..2^PCW-1
- PCW, 4: width of pass counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a sweep; ignored unless IDLE
- abort  in  1  return to IDLE immediately, no done pulse
- pause  in  1  while high in RUN, counter enable held low
- cnt_in  in  8  current counter value
- co_in  in  1  counter carry-out; rises on the edge where the counter wraps 255→0, stays high until the next enabled increment
- en_cnt  out  1  counter enable (combinational from state/inputs)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of sweep
- pass_cnt  out  PCW  carry events seen in current/last sweep
- err  out  1  sticky consistency error (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: en_cnt=0, busy=0. start=1 → RUN; pass_cnt cleared to 0 on the same edge.
- RUN: en_cnt = ~pause & ~(co_rise & last); co_rise = co_in & ~co_q; last = (pass_cnt == PASSES-1).
- co_q: register tracking co_in every cycle in all states, so a stale high co_in from a previous sweep is never counted.
- On co_rise in RUN: pass_cnt += 1. If last: → DONE. en_cnt is already low that cycle, so the counter stays at 0.
- DONE: en_cnt=0, done=1 for exactly one cycle → IDLE.
- abort (any state, priority over start/co_rise): → IDLE next edge; en_cnt forced 0 in the abort cycle; pass_cnt holds.
- pause: has no effect on state or counting; only gates en_cnt.
- pass_cnt holds its value after DONE until the next accepted start.
- Simultaneous start and abort in IDLE: abort wins and the block stays IDLE.
- Reset values: state=IDLE, en_cnt=0, busy=0, done=0, pass_cnt=0, co_q=0, err=0. Reset mid-sweep: the block drops to IDLE immediately, with no done.

## Timing
- start sampled at edge 0 → RUN after edge 0; en_cnt high from that cycle.
- From cnt_in=c with no pause, the counter's first wrap occurs at edge 256-c. co_rise is seen in the following cycle.
- For the final pass: DONE is entered at wrap edge + 1. done is high between wrap+1 and wrap+2. busy falls after wrap+2.
- Each paused cycle in RUN delays every later event by one cycle.
- No output is registered except via state; done and busy follow state directly.

## Configuration
- SWEEP_CHECK_EN defined: add an 8-bit shadow register exp.
  - exp is loaded with cnt_in on an accepted start.
  - exp increments (mod 256) on every edge where en_cnt=1.
  - While state is RUN, cnt_in != exp sets err=1.
  - err is sticky and is cleared only by rst or an accepted start.
- SWEEP_CHECK_EN undefined: no shadow logic; err tied 0. Port list is identical in both builds.

## Test plan
- PASSES=1, counter at 0, start at edge 0, no pause → en_cnt high 256 cycles, wrap at edge 256, done high between edges 257–258, cnt_in=0 at end, pass_cnt=1.
- PASSES=3, counter at 0 → done after edge 769; pass_cnt=3; counter never advances past 0 after the final wrap.
- Counter at 200, PASSES=1 → wrap at edge 56, done after edge 57. Also pause high for 10 cycles mid-run → done after edge 67.
- Stale co_in=1 at start (counter left at 0 by the previous sweep), PASSES=1 → co_in is not counted; full 256 increments occur before done.
- abort during RUN at edge 100 → en_cnt low in the abort cycle, IDLE after edge 100, no done pulse. start during RUN or DONE is ignored.
- SWEEP_CHECK_EN: force cnt_in to 50 while exp=40 in RUN → err=1 next edge and stays 1 after done; next start clears it. Without the macro, err stays 0.

Source files
------------

// File: rtl/sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_ctrl
//
// Sequencer for the 8-bit address counter of the sort/selection datapath.
// A start pulse enables the counter. Each wrap 255->0 reported on co_in counts
// as one pass. On the final wrap the counter enable is dropped in the same
// cycle, so the counter rests at 0. The block then emits a one-cycle done
// pulse and returns to IDLE.
//
// Parameters
//   PASSES  number of counter wraps per sweep (1 .. 2**PCW-1)
//   PCW     width of the pass counter
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-high reset
//   start     in   single-cycle sweep request; only accepted in IDLE
//   abort     in   return to IDLE on the next edge, no done pulse
//   pause     in   in RUN, holds the counter enable low
//   cnt_in    in   current counter value (8 bits)
//   co_in     in   counter carry-out; rises on the wrap edge, stays high
//                  until the next enabled increment
//   en_cnt    out  counter enable (combinational)
//   busy      out  high in RUN and DONE
//   done      out  one-cycle end-of-sweep pulse
//   pass_cnt  out  wraps seen in the current or last sweep (PCW bits)
//   err       out  sticky counter/shadow mismatch flag
//
// Handshake: this block is the initiator. en_cnt is a request to advance the
// counter on the next rising edge. co_in is the counter's only response, and
// only its rising edge (co_in high now, low last cycle) is treated as an event.
//
// Build option: define SWEEP_CHECK_EN to add an 8-bit shadow of the counter.
// The shadow loads cnt_in on an accepted start and follows en_cnt. Any
// difference from cnt_in while in RUN sets err. err is cleared by rst or by
// the next accepted start. When the macro is undefined, err is tied to 0.
// -----------------------------------------------------------------------------
module sweep_ctrl #(
  parameter int PASSES = 1,
  parameter int PCW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           pause,
  input  logic [7:0]     cnt_in,
  input  logic           co_in,
  output logic           en_cnt,
  output logic           busy,
  output logic           done,
  output logic [PCW-1:0] pass_cnt,
  output logic           err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic co_q;
  logic co_rise;
  logic last;
  logic start_ok;
  logic pass_inc;

  // co_q runs in every state. A carry left high by the previous sweep is
  // therefore already in co_q by the time a new sweep starts, and it does
  // not appear as a fresh event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) co_q <= 1'b0;
    else     co_q <= co_in;
  end

  assign co_rise  = co_in & ~co_q;
  assign last     = (pass_cnt == PCW'(PASSES - 1));
  assign start_ok = (state == IDLE) & start & ~abort;
  assign pass_inc = (state == RUN) & co_rise & ~abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_cnt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // The enable drops in the cycle the final wrap is seen, so the
        // counter stays at 0 rather than stepping to 1.
        en_cnt = ~pause & ~(co_rise & last);
        if (co_rise && last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // abort overrides everything, including a start in IDLE.
    if (abort) begin
      state_nxt = IDLE;
      en_cnt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pass_cnt <= '0;
    else if (start_ok) pass_cnt <= '0;
    else if (pass_inc) pass_cnt <= pass_cnt + 1'b1;
  end

  assign busy = (state == RUN) | (state == DONE);
  assign done = (state == DONE);

`ifdef SWEEP_CHECK_EN
  logic [7:0] exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp <= 8'd0;
      err <= 1'b0;
    end else if (start_ok) begin
      exp <= cnt_in;
      err <= 1'b0;
    end else begin
      if (en_cnt) exp <= exp + 8'd1;
      if ((state == RUN) && (cnt_in != exp)) err <= 1'b1;
    end
  end
`else
  // Without the shadow, cnt_in has no consumer.
  logic unused_cnt_in;
  assign unused_cnt_in = ^cnt_in;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sweep_ctrl
//
// Drives two sweep_ctrl instances. u1 runs with PASSES=1 and u3 with
// PASSES=3. Each instance is paired with a behavioural model of the 8-bit
// address counter. The model increments on en_cnt and raises co on the wrap
// edge. It can be preloaded with a value and a carry level. The cnt_in input
// of u1 can also be overridden, which is used to provoke the shadow check.
// -----------------------------------------------------------------------------
module tb_sweep_ctrl;

  localparam int PCW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [1:0]     start;
  logic           abort;
  logic           pause;
  logic [1:0]     load;
  logic [7:0]     load_val;
  logic           load_co;
  logic           force_en;
  logic [7:0]     force_val;

  logic [7:0]     cnt [2];
  logic [1:0]     co;
  logic [7:0]     cnt_in0;

  logic [1:0]     en;
  logic [1:0]     busy;
  logic [1:0]     done;
  logic [1:0]     err;
  logic [PCW-1:0] pass0;
  logic [PCW-1:0] pass1;

  int n_cmp;
  int n_bad;

  assign cnt_in0 = force_en ? force_val : cnt[0];

  // Counter models. co rises on the wrap edge and clears on the next
  // enabled increment.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load[k]) begin
        cnt[k] <= load_val;
        co[k]  <= load_co;
      end else if (en[k]) begin
        cnt[k] <= cnt[k] + 8'd1;
        co[k]  <= (cnt[k] == 8'hff);
      end
    end
  end

  sweep_ctrl #(.PASSES(1), .PCW(PCW)) u1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start[0]),
    .abort    (abort),
    .pause    (pause),
    .cnt_in   (cnt_in0),
    .co_in    (co[0]),
    .en_cnt   (en[0]),
    .busy     (busy[0]),
    .done     (done[0]),
    .pass_cnt (pass0),
    .err      (err[0])
  );

  sweep_ctrl #(.PASSES(3), .PCW(PCW)) u3 (
    .clk      (clk),
    .rst      (rst),
    .start    (start[1]),
    .abort    (abort),
    .pause    (pause),
    .cnt_in   (cnt[1]),
    .co_in    (co[1]),
    .en_cnt   (en[1]),
    .busy     (busy[1]),
    .done     (done[1]),
    .pass_cnt (pass1),
    .err      (err[1])
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start; the edge consumed here is "edge 0" of the sweep.
  task automatic kick(input int k);
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
  endtask

  task automatic preload(input int k, input logic [7:0] v, input logic c);
    load[k]  = 1'b1;
    load_val = v;
    load_co  = c;
    step();
    load[k]  = 1'b0;
    step();
  endtask

  // Steps until done is seen. Returns the edge index, counted from the
  // caller's current edge, and the number of cycles with en_cnt high
  // before that edge. A budget overrun is reported as a failed comparison.
  task automatic run_until_done(input int k, input int max_edges,
                                output int edge_n, output int en_cycles);
    edge_n    = -1;
    en_cycles = 0;
    for (int i = 1; i <= max_edges; i++) begin
      if (en[k]) en_cycles++;
      step();
      if (done[k]) begin
        edge_n = i;
        break;
      end
    end
    if (edge_n < 0) check("done_timeout", 0, 1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // ---------------- test sequence ----------------
  int e;
  int en_n;
  int done_seen;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 2'b00;
    abort     = 1'b0;
    pause     = 1'b0;
    load      = 2'b11;
    load_val  = 8'd0;
    load_co   = 1'b0;
    force_en  = 1'b0;
    force_val = 8'd0;
    step();
    step();

    // Reset state
    check("rst_busy",  int'(busy[0]), 0);
    check("rst_done",  int'(done[0]), 0);
    check("rst_en",    int'(en[0]),   0);
    check("rst_pass",  int'(pass0),   0);
    check("rst_err",   int'(err[0]),  0);
    check("rst_busy3", int'(busy[1]), 0);
    rst  = 1'b0;
    load = 2'b00;
    step();

    // PASSES=1 from 0: 256 enabled cycles, done after edge 257
    kick(0);
    check("t1_busy", int'(busy[0]), 1);
    check("t1_en",   int'(en[0]),   1);
    run_until_done(0, 400, e, en_n);
    check("t1_done_edge", e, 257);
    check("t1_en_cycles", en_n, 256);
    check("t1_pass", int'(pass0), 1);
    check("t1_cnt",  int'(cnt[0]), 0);
    check("t1_busy_done", int'(busy[0]), 1);
    // start raised during DONE must be ignored
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("t1_idle_busy", int'(busy[0]), 0);
    check("t1_done_pulse", int'(done[0]), 0);
    check("t1_pass_hold", int'(pass0), 1);

    // Stale carry from the last sweep is still high: must not count
    kick(0);
    check("t2_no_early_done", int'(done[0]), 0);
    run_until_done(0, 400, e, en_n);
    check("t2_done_edge", e, 257);
    check("t2_en_cycles", en_n, 256);
    check("t2_pass", int'(pass0), 1);

    // PASSES=3 from 0: done after edge 769
    kick(1);
    run_until_done(1, 1000, e, en_n);
    check("t3_done_edge", e, 769);
    check("t3_en_cycles", en_n, 768);
    check("t3_pass", int'(pass1), 3);
    step();
    step();
    step();
    check("t3_cnt_rest", int'(cnt[1]), 0);
    check("t3_en_off",   int'(en[1]),  0);

    // Counter at 200: wrap at edge 56, done after edge 57
    preload(0, 8'd200, 1'b0);
    kick(0);
    run_until_done(0, 200, e, en_n);
    check("t4_done_edge", e, 57);
    check("t4_pass", int'(pass0), 1);

    // Same with 10 paused cycles mid-run: done after edge 67
    preload(0, 8'd200, 1'b0);
    kick(0);
    for (int i = 0; i < 10; i++) step();
    pause = 1'b1;
    #1;
    check("t5_pause_en",   int'(en[0]),   0);
    check("t5_pause_busy", int'(busy[0]), 1);
    for (int i = 0; i < 10; i++) step();
    pause = 1'b0;
    run_until_done(0, 200, e, en_n);
    check("t5_done_edge", e + 20, 67);
    check("t5_cnt", int'(cnt[0]), 0);

    // abort at edge 100: enable low in the abort cycle, no done
    preload(0, 8'd0, 1'b0);
    kick(0);
    done_seen = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (done[0]) done_seen++;
    end
    abort = 1'b1;
    #1;
    check("t6_abort_en", int'(en[0]), 0);
    step();
    abort = 1'b0;
    check("t6_idle_busy", int'(busy[0]), 0);
    check("t6_cnt", int'(cnt[0]), 99);
    check("t6_pass_hold", int'(pass0), 0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (done[0]) done_seen++;
    end
    check("t6_no_done", done_seen, 0);
    check("t6_cnt_frozen", int'(cnt[0]), 99);

    // start and abort together in IDLE: abort wins
    start[0] = 1'b1;
    abort    = 1'b1;
    step();
    start[0] = 1'b0;
    abort    = 1'b0;
    check("t7_busy", int'(busy[0]), 0);
    step();
    check("t7_busy_stay", int'(busy[0]), 0);

    // Async reset mid-sweep on u3 after its first wrap
    preload(1, 8'd0, 1'b0);
    kick(1);
    for (int i = 0; i < 300; i++) step();
    check("t8_pass_before", int'(pass1), 1);
    rst = 1'b1;
    #1;
    check("t8_busy", int'(busy[1]), 0);
    check("t8_en",   int'(en[1]),   0);
    check("t8_pass", int'(pass1),   0);
    check("t8_done", int'(done[1]), 0);
    step();
    rst = 1'b0;
    step();
    check("t8_idle", int'(busy[1]), 0);

`ifdef SWEEP_CHECK_EN
    // Shadow check: cnt_in forced to 50 while the shadow holds 40
    preload(0, 8'd0, 1'b0);
    kick(0);
    for (int i = 0; i < 40; i++) step();
    check("t9_err_clean", int'(err[0]), 0);
    force_en  = 1'b1;
    force_val = 8'd50;
    step();
    force_en  = 1'b0;
    check("t9_err_set", int'(err[0]), 1);
    run_until_done(0, 400, e, en_n);
    check("t9_done_edge", e + 41, 257);
    check("t9_err_sticky", int'(err[0]), 1);
    step();
    check("t9_err_idle", int'(err[0]), 1);
    kick(0);
    check("t9_err_clear", int'(err[0]), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`else
    check("t9_err_off_u1", int'(err[0]), 0);
    check("t9_err_off_u3", int'(err[1]), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
